mem_arbiter: RTL

Shares the single byte-wide unified RAM port between instruction fetch (IF) and the MEM stage's loads/stores. Serialises each 8/16/32-bit request into byte cycles and assembles read data little-endian. Signals completion with one-cycle done pulses. Sits between the IF/MEM pipeline stages and the RAM; MEM requests have priority over IF.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one unified RAM port between instruction fetch and MEM loads/stores.
// MEM has priority; 8/16/32-bit requests become byte cycles, read data assembled little-endian.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_done_o,
    output logic [31:0]           if_data_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_len_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_done_o,
    output logic [31:0]           mem_rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state, state_next;
    logic                    owner_mem;
    logic [ADDR_WIDTH-1:0]   base;
    logic [2:0]              n;
    logic [2:0]              cnt;
    logic [31:0]             data;
    logic [31:0]             wdata;
    logic [31:0]             if_hold;
    logic [31:0]             mem_hold;
    logic [31:0]             wdata_shift;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        ram_wr_o    = 1'b0;
        ram_addr_o  = '0;
        ram_dout_o  = '0;
        wdata_shift = wdata >> {cnt[1:0], 3'b000};
        busy_o      = (state != IDLE);
        if_done_o   = 1'b0;
        mem_done_o  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i)                      state_next = mem_we_i ? WRITE : READ;
                else if (if_req_i && !if_flush_i)   state_next = READ;
            end
            READ: begin
                // one extra cycle (cnt == n) drains the last byte from the RAM's one-cycle latency
                if (cnt < n) ram_addr_o = base + ADDR_WIDTH'(cnt);
                if (!owner_mem && if_flush_i) state_next = IDLE;
                else if (cnt == n)            state_next = DONE;
            end
            WRITE: begin
                ram_wr_o   = 1'b1;
                ram_addr_o = base + ADDR_WIDTH'(cnt);
                ram_dout_o = wdata_shift[7:0];
                if (cnt == n - 3'd1) state_next = DONE;
            end
            DONE: begin
                if_done_o  = !owner_mem && !if_flush_i;
                mem_done_o = owner_mem;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if_data_o   = if_done_o  ? data : if_hold;
        mem_rdata_o = mem_done_o ? data : mem_hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_mem <= 1'b0;
            base      <= '0;
            n         <= '0;
            cnt       <= '0;
            data      <= '0;
            wdata     <= '0;
            if_hold   <= '0;
            mem_hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    data <= '0;
                    if (mem_req_i) begin
                        owner_mem <= 1'b1;
                        base      <= mem_addr_i;
                        wdata     <= mem_wdata_i;
                        case (mem_len_i)
                            2'b00:   n <= 3'd1;
                            2'b01:   n <= 3'd2;
                            default: n <= 3'd4;
                        endcase
                    end else if (if_req_i && !if_flush_i) begin
                        owner_mem <= 1'b0;
                        base      <= if_addr_i;
                        n         <= 3'd4;
                    end
                end
                READ: begin
                    case (cnt)
                        3'd1:    data[7:0]   <= ram_din_i;
                        3'd2:    data[15:8]  <= ram_din_i;
                        3'd3:    data[23:16] <= ram_din_i;
                        3'd4:    data[31:24] <= ram_din_i;
                        default: ;
                    endcase
                    cnt <= cnt + 3'd1;
                end
                WRITE: cnt <= cnt + 3'd1;
                DONE: begin
                    if (if_done_o)  if_hold  <= data;
                    if (mem_done_o) mem_hold <= data;
                end
                default: ;
            endcase
        end
    end

endmodule
